// File: rtl/light_pkg.sv
`default_nettype none
// ============================================================================
// Module      : light_pkg
// Description : Shared light codes, error codes and the legal-transition rule
//               for the traffic-light state bank.
// Revision    : 1.0 - initial release
// ============================================================================
package light_pkg;

    localparam logic [2:0] LIGHT_RED   = 3'b001;
    localparam logic [2:0] LIGHT_AMBER = 3'b010;
    localparam logic [2:0] LIGHT_GREEN = 3'b100;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_BADCODE  = 3'd1;
    localparam logic [2:0] ERR_SEQ      = 3'd2;
    localparam logic [2:0] ERR_CONFLICT = 3'd3;
    localparam logic [2:0] ERR_DWELL    = 3'd4;

    function automatic logic is_light_code(input logic [2:0] code);
        return (code == LIGHT_RED) || (code == LIGHT_AMBER) || (code == LIGHT_GREEN);
    endfunction

    // Refresh of the same colour is always a legal sequence step.
    function automatic logic legal_transition(input logic [2:0] from_code,
                                              input logic [2:0] to_code);
        return (from_code == to_code)
            || ((from_code == LIGHT_RED)   && (to_code == LIGHT_GREEN))
            || ((from_code == LIGHT_GREEN) && (to_code == LIGHT_AMBER))
            || ((from_code == LIGHT_AMBER) && (to_code == LIGHT_RED));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : dwell_counter
// Description : Per-road minimum-dwell down counter; reload on colour change,
//               saturating decrement, clear on emergency.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_counter #(
    parameter int min_dwell = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic clear,
    output logic zero
);

    localparam int CNT_W = (min_dwell > 0) ? $clog2(min_dwell + 1) : 1;
    localparam logic [CNT_W-1:0] RELOAD_VAL = CNT_W'(min_dwell);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear beats load so an emergency edge always leaves the road free to change.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = RELOAD_VAL;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/light_state_bank.sv
`default_nettype none
// ============================================================================
// Module      : light_state_bank
// Description : Clocked per-road light-state bank with write legality checks,
//               error reporting and emergency all-red override.
// Revision    : 1.0 - initial release
// ============================================================================
module light_state_bank
    import light_pkg::*;
#(
    parameter int roads       = 4,
    parameter int light_width = 3,
    parameter int min_dwell   = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(roads)-1:0]     wr_road,
    input  logic [light_width-1:0]       wr_light,
    input  logic                         emergency,
    output logic [roads*light_width-1:0] lights_flat,
    output logic                         green_any,
    output logic                         wr_err,
    output logic [2:0]                   err_code
);

    logic [roads-1:0][light_width-1:0] lights_q;
    logic [roads-1:0][light_width-1:0] lights_d;
    logic                              wr_err_q;
    logic                              wr_err_d;
    logic [2:0]                        err_code_q;
    logic [2:0]                        err_code_d;
    logic [roads-1:0]                  dwell_zero;
    logic [roads-1:0]                  dwell_load;

    logic                   accept;
    logic                   road_ok;
    logic [light_width-1:0] cur_light;
    logic                   cur_zero;
    logic                   other_busy;
    logic [2:0]             check_code;

    assign wr_ready = !emergency && !reset;
    assign accept   = wr_valid && wr_ready;
    assign road_ok  = (int'(wr_road) < roads);

    // Gather the target road's state and whether any other road holds right of way.
    always_comb begin
        cur_light  = LIGHT_RED;
        cur_zero   = 1'b1;
        other_busy = 1'b0;
        for (int r = 0; r < roads; r++) begin
            if (road_ok && (r == int'(wr_road))) begin
                cur_light = lights_q[r];
                cur_zero  = dwell_zero[r];
            end else if ((lights_q[r] & (LIGHT_GREEN | LIGHT_AMBER)) != '0) begin
                other_busy = 1'b1;
            end
        end
    end

    always_comb begin
        if (!road_ok || !is_light_code(wr_light)) begin
            check_code = ERR_BADCODE;
        end else if (!legal_transition(cur_light, wr_light)) begin
            check_code = ERR_SEQ;
        end else if ((wr_light != cur_light) && !cur_zero) begin
            check_code = ERR_DWELL;
        end else if ((wr_light == LIGHT_GREEN) && other_busy) begin
            check_code = ERR_CONFLICT;
        end else begin
            check_code = ERR_NONE;
        end
    end

    always_comb begin
        lights_d   = lights_q;
        wr_err_d   = 1'b0;
        err_code_d = err_code_q;
        dwell_load = '0;
        if (emergency) begin
            lights_d = {roads{LIGHT_RED}};
        end else if (accept) begin
            err_code_d = check_code;
            if (check_code == ERR_NONE) begin
                lights_d[wr_road] = wr_light;
                if (wr_light != cur_light) begin
                    dwell_load[wr_road] = 1'b1;
                end
            end else begin
                wr_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lights_q   <= {roads{LIGHT_RED}};
            wr_err_q   <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            lights_q   <= lights_d;
            wr_err_q   <= wr_err_d;
            err_code_q <= err_code_d;
        end
    end

    generate
        for (genvar r = 0; r < roads; r++) begin : g_dwell
            dwell_counter #(
                .min_dwell(min_dwell)
            ) u_dwell (
                .clk  (clk),
                .reset(reset),
                .load (dwell_load[r]),
                .clear(emergency),
                .zero (dwell_zero[r])
            );
        end
    endgenerate

    always_comb begin
        green_any = 1'b0;
        for (int r = 0; r < roads; r++) begin
            green_any = green_any | lights_q[r][2];
        end
    end

    assign lights_flat = lights_q;
    assign wr_err      = wr_err_q;
    assign err_code    = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_light_state_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_state_bank
// Description : Directed plus randomized self-checking bench for the light
//               state bank against a cycle-count based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_state_bank;
    import light_pkg::*;

    localparam int ROADS     = 4;
    localparam int LW        = 3;
    localparam int MIN_DWELL = 15;

    logic                  clk       = 1'b0;
    logic                  reset     = 1'b0;
    logic                  wr_valid  = 1'b0;
    logic                  emergency = 1'b0;
    logic [1:0]            wr_road   = 2'd0;
    logic [LW-1:0]         wr_light  = 3'b001;
    logic                  wr_ready;
    logic [ROADS*LW-1:0]   lights_flat;
    logic                  green_any;
    logic                  wr_err;
    logic [2:0]            err_code;

    light_state_bank #(
        .roads      (ROADS),
        .light_width(LW),
        .min_dwell  (MIN_DWELL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_road    (wr_road),
        .wr_light   (wr_light),
        .emergency  (emergency),
        .lights_flat(lights_flat),
        .green_any  (green_any),
        .wr_err     (wr_err),
        .err_code   (err_code)
    );

    always #5 clk = ~clk;

    // Reference model: colours per road plus the edge index of the last colour change.
    logic [2:0] m_light [ROADS];
    int         m_last  [ROADS];
    logic       m_err;
    logic [2:0] m_code;
    int         cyc;
    int         checks;
    int         passes;
    int         fails;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] succ(input logic [2:0] c);
        case (c)
            3'b001:  return 3'b100;
            3'b100:  return 3'b010;
            3'b010:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [ROADS*LW-1:0] m_flat();
        logic [ROADS*LW-1:0] f;
        for (int r = 0; r < ROADS; r++) f[r*LW +: LW] = m_light[r];
        return f;
    endfunction

    function automatic logic m_green_any();
        logic g = 1'b0;
        for (int r = 0; r < ROADS; r++) if (m_light[r] == 3'b100) g = 1'b1;
        return g;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < ROADS; r++) begin
            m_light[r] = 3'b001;
            m_last[r]  = -1000;
        end
        m_err  = 1'b0;
        m_code = 3'd0;
    endtask

    task automatic model_edge();
        int         r;
        int         code;
        logic [2:0] cur;
        logic       busy;
        cyc++;
        m_err = 1'b0;
        if (emergency) begin
            for (int k = 0; k < ROADS; k++) begin
                m_light[k] = 3'b001;
                m_last[k]  = -1000;
            end
        end else if (wr_valid) begin
            r = int'(wr_road);
            if (r >= ROADS || !(wr_light inside {3'b001, 3'b010, 3'b100})) begin
                code = 1;
            end else begin
                cur  = m_light[r];
                busy = 1'b0;
                for (int k = 0; k < ROADS; k++)
                    if (k != r && m_light[k] != 3'b001) busy = 1'b1;
                if (wr_light != cur && wr_light != succ(cur))               code = 2;
                else if (wr_light != cur && (cyc - m_last[r]) <= MIN_DWELL) code = 4;
                else if (wr_light == 3'b100 && busy)                        code = 3;
                else                                                        code = 0;
                if (code == 0 && wr_light != cur) begin
                    m_light[r] = wr_light;
                    m_last[r]  = cyc;
                end
            end
            m_code = 3'(code);
            m_err  = (code != 0);
        end
    endtask

    task automatic check_all();
        check("lights_flat", 32'(lights_flat), 32'(m_flat()));
        check("green_any", 32'(green_any), 32'(m_green_any()));
        check("wr_err", 32'(wr_err), 32'(m_err));
        check("err_code", 32'(err_code), 32'(m_code));
    endtask

    task automatic tick();
        #1;
        check("wr_ready", 32'(wr_ready), 32'(!emergency && !reset));
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic write(input logic [1:0] road, input logic [2:0] light);
        wr_valid = 1'b1;
        wr_road  = road;
        wr_light = light;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [2:0] codes [3];
        int         sel;
        checks = 0;
        passes = 0;
        fails  = 0;
        cyc    = 0;
        codes[0] = LIGHT_RED;
        codes[1] = LIGHT_AMBER;
        codes[2] = LIGHT_GREEN;
        model_reset();

        for (int a = 0; a < 3; a++)
            for (int b = 0; b < 3; b++)
                check("legal_fn", 32'(legal_transition(codes[a], codes[b])),
                      32'((codes[a] == codes[b]) || (codes[b] == succ(codes[a]))));

        // Reset before any clock edge must take effect asynchronously.
        #1 reset = 1'b1;
        #1;
        check("reset_lights", 32'(lights_flat), 32'h249);
        check("reset_ready", 32'(wr_ready), 32'd0);
        check("reset_err", 32'(wr_err), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("rel_lights", 32'(lights_flat), 32'h249);
        check("rel_green_any", 32'(green_any), 32'd0);
        check("rel_ready", 32'(wr_ready), 32'd1);
        check("rel_code", 32'(err_code), 32'd0);

        write(2'd0, LIGHT_GREEN);
        check("road0_green", 32'(lights_flat[2:0]), 32'h4);
        check("green_any_1", 32'(green_any), 32'd1);
        write(2'd1, LIGHT_GREEN);
        check("conflict_code", 32'(err_code), 32'd3);
        check("conflict_err", 32'(wr_err), 32'd1);
        check("road1_red", 32'(lights_flat[5:3]), 32'h1);

        idle(3);
        write(2'd0, LIGHT_AMBER);
        check("dwell_code", 32'(err_code), 32'd4);
        idle(10);
        write(2'd0, LIGHT_AMBER);
        check("dwell_done", 32'(lights_flat[2:0]), 32'h2);
        check("dwell_done_err", 32'(wr_err), 32'd0);

        write(2'd2, LIGHT_AMBER);
        check("seq_code", 32'(err_code), 32'd2);
        write(2'd2, 3'b011);
        check("bad_code", 32'(err_code), 32'd1);
        write(2'd2, LIGHT_RED);
        check("refresh_code", 32'(err_code), 32'd0);
        check("refresh_err", 32'(wr_err), 32'd0);

        idle(16);
        write(2'd0, LIGHT_RED);
        idle(16);
        write(2'd0, LIGHT_GREEN);

        // Emergency with a pending write; road0's fresh dwell must be cleared.
        emergency = 1'b1;
        wr_valid  = 1'b1;
        wr_road   = 2'd1;
        wr_light  = LIGHT_GREEN;
        tick();
        check("emerg_lights", 32'(lights_flat), 32'h249);
        check("emerg_err", 32'(wr_err), 32'd0);
        idle(2);
        emergency = 1'b0;
        wr_valid  = 1'b0;
        write(2'd0, LIGHT_GREEN);
        check("post_emerg_code", 32'(err_code), 32'd0);
        check("post_emerg_light", 32'(lights_flat[2:0]), 32'h4);

        // Asynchronous reset mid-cycle.
        #2 reset = 1'b1;
        model_reset();
        #1;
        check("async_lights", 32'(lights_flat), 32'h249);
        check("async_green_any", 32'(green_any), 32'd0);
        #3 reset = 1'b0;
        write(2'd0, LIGHT_GREEN);
        check("post_reset_code", 32'(err_code), 32'd0);
        check("post_reset_light", 32'(lights_flat[2:0]), 32'h4);

        for (int i = 0; i < 500; i++) begin
            emergency = ($urandom_range(0, 24) == 0);
            wr_valid  = ($urandom_range(0, 2) == 0);
            wr_road   = 2'($urandom_range(0, 3));
            sel       = int'($urandom_range(0, 9));
            if (sel < 6)      wr_light = succ(m_light[wr_road]);
            else if (sel < 8) wr_light = m_light[wr_road];
            else              wr_light = 3'($urandom_range(0, 7));
            tick();
        end
        emergency = 1'b0;
        wr_valid  = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
